tl_bus_arbiter: RTL and testbench

// - Shares one TileLink master port to memory between the two CPU requesters: fetch (IF) and access (MA).
// - One transaction outstanding at a time. MA has priority; a starvation counter bounds IF latency.
// - Handles pipeline clear: a fetch transaction that is cancelled after issue is drained and its response discarded.
// - Sits between cpu (if_bus/ma_bus plus request lines) and the SoC interconnect.

---
 rtl/tl_arb_pkg.sv | 8 +
 rtl/tl_arb_mux.sv | 68 ++++++
 rtl/tl_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_tl_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg: shared types and widths for the TileLink bus arbiter
package tl_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_A, WAIT_D} arb_state_t;
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_MA} arb_owner_t;
  localparam int STARVE_W = 4;
  localparam int AW = 32;
  localparam int DW = 32;
endpackage

// File: rtl/tl_arb_mux.sv
// tl_arb_mux: steers A/D channels between the owning requester and the shared memory port
module tl_arb_mux
  import tl_arb_pkg::*;
(
  input  logic            sel_if,
  input  logic            sel_ma,
  input  logic            a_phase,
  input  logic            d_phase,
  input  logic            kill,
  input  logic            discard,
  input  logic            if_a_valid,
  output logic            if_a_ready,
  input  logic [2:0]      if_a_opcode,
  input  logic [1:0]      if_a_size,
  input  logic [AW-1:0]   if_a_address,
  input  logic [DW/8-1:0] if_a_mask,
  input  logic [DW-1:0]   if_a_data,
  output logic            if_d_valid,
  input  logic            if_d_ready,
  output logic [2:0]      if_d_opcode,
  output logic [DW-1:0]   if_d_data,
  output logic            if_d_error,
  input  logic            ma_a_valid,
  output logic            ma_a_ready,
  input  logic [2:0]      ma_a_opcode,
  input  logic [1:0]      ma_a_size,
  input  logic [AW-1:0]   ma_a_address,
  input  logic [DW/8-1:0] ma_a_mask,
  input  logic [DW-1:0]   ma_a_data,
  output logic            ma_d_valid,
  input  logic            ma_d_ready,
  output logic [2:0]      ma_d_opcode,
  output logic [DW-1:0]   ma_d_data,
  output logic            ma_d_error,
  output logic            mem_a_valid,
  input  logic            mem_a_ready,
  output logic [2:0]      mem_a_opcode,
  output logic [1:0]      mem_a_size,
  output logic [AW-1:0]   mem_a_address,
  output logic [DW/8-1:0] mem_a_mask,
  output logic [DW-1:0]   mem_a_data,
  input  logic            mem_d_valid,
  output logic            mem_d_ready,
  input  logic [2:0]      mem_d_opcode,
  input  logic [DW-1:0]   mem_d_data,
  input  logic            mem_d_error
);
  always_comb begin
    mem_a_valid   = a_phase & (sel_ma ? ma_a_valid : sel_if & ~kill & if_a_valid);
    mem_a_opcode  = sel_ma ? ma_a_opcode : if_a_opcode;
    mem_a_size    = sel_ma ? ma_a_size : if_a_size;
    mem_a_address = sel_ma ? ma_a_address : if_a_address;
    mem_a_mask    = sel_ma ? ma_a_mask : if_a_mask;
    mem_a_data    = sel_ma ? ma_a_data : if_a_data;
    if_a_ready    = a_phase & sel_if & ~kill & mem_a_ready;
    ma_a_ready    = a_phase & sel_ma & mem_a_ready;
    // a discarded fetch response is swallowed here: always accepted, never shown to IF
    if_d_valid    = d_phase & sel_if & ~discard & mem_d_valid;
    ma_d_valid    = d_phase & sel_ma & mem_d_valid;
    mem_d_ready   = d_phase & (discard | (sel_ma ? ma_d_ready : sel_if & if_d_ready));
    if_d_opcode   = mem_d_opcode;
    if_d_data     = mem_d_data;
    if_d_error    = mem_d_error;
    ma_d_opcode   = mem_d_opcode;
    ma_d_data     = mem_d_data;
    ma_d_error    = mem_d_error;
  end
endmodule

// File: rtl/tl_bus_arbiter.sv
// tl_bus_arbiter: shares one TileLink memory port between fetch (IF) and access (MA),
// one transaction at a time, MA first with a starvation bound for IF.
module tl_bus_arbiter
  import tl_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            if_request,
  input  logic            if_a_valid,
  output logic            if_a_ready,
  input  logic [2:0]      if_a_opcode,
  input  logic [1:0]      if_a_size,
  input  logic [AW-1:0]   if_a_address,
  input  logic [DW/8-1:0] if_a_mask,
  input  logic [DW-1:0]   if_a_data,
  output logic            if_d_valid,
  input  logic            if_d_ready,
  output logic [2:0]      if_d_opcode,
  output logic [DW-1:0]   if_d_data,
  output logic            if_d_error,
  input  logic            ma_request,
  input  logic            ma_a_valid,
  output logic            ma_a_ready,
  input  logic [2:0]      ma_a_opcode,
  input  logic [1:0]      ma_a_size,
  input  logic [AW-1:0]   ma_a_address,
  input  logic [DW/8-1:0] ma_a_mask,
  input  logic [DW-1:0]   ma_a_data,
  output logic            ma_d_valid,
  input  logic            ma_d_ready,
  output logic [2:0]      ma_d_opcode,
  output logic [DW-1:0]   ma_d_data,
  output logic            ma_d_error,
  output logic            mem_a_valid,
  input  logic            mem_a_ready,
  output logic [2:0]      mem_a_opcode,
  output logic [1:0]      mem_a_size,
  output logic [AW-1:0]   mem_a_address,
  output logic [DW/8-1:0] mem_a_mask,
  output logic [DW-1:0]   mem_a_data,
  input  logic            mem_d_valid,
  output logic            mem_d_ready,
  input  logic [2:0]      mem_d_opcode,
  input  logic [DW-1:0]   mem_d_data,
  input  logic            mem_d_error,
  output logic            grant_if,
  output logic            grant_ma,
  output logic            busy
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
  arb_state_t          state;
  arb_owner_t          owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                discard;
  logic                if_req, ma_ok, win_if, win_ma, kill, a_fire, d_fire, rel;
  always_comb begin
    if_req = if_request & ~clear;
    ma_ok  = ma_request & (starve_cnt < LIMIT);
    win_ma = ma_ok | (ma_request & ~if_req);
    win_if = if_req & ~ma_ok;
    kill   = (owner == OWN_IF) & clear;
    a_fire = mem_a_valid & mem_a_ready;
    d_fire = mem_d_valid & mem_d_ready;
    rel    = ((state == GRANT_A) & kill) | ((state == WAIT_D) & d_fire);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= NONE;
      grant_if   <= 1'b0;
      grant_ma   <= 1'b0;
      busy       <= 1'b0;
      starve_cnt <= '0;
      discard    <= 1'b0;
    end else if (rel) begin
      state    <= IDLE;
      owner    <= NONE;
      grant_if <= 1'b0;
      grant_ma <= 1'b0;
      busy     <= 1'b0;
      discard  <= 1'b0;
    end else if (state == IDLE && (win_if | win_ma)) begin
      state      <= GRANT_A;
      owner      <= win_if ? OWN_IF : OWN_MA;
      grant_if   <= win_if;
      grant_ma   <= win_ma;
      busy       <= 1'b1;
      // an MA win over a waiting IF implies starve_cnt < LIMIT, so this saturates at LIMIT
      starve_cnt <= (win_ma & if_req) ? starve_cnt + STARVE_W'(1) : '0;
    end else if (state == GRANT_A && a_fire) begin
      state <= WAIT_D;
    end else if (state == WAIT_D && kill) begin
      discard <= 1'b1;
    end
  end
  tl_arb_mux u_mux (
    .sel_if        (owner == OWN_IF),
    .sel_ma        (owner == OWN_MA),
    .a_phase       (state == GRANT_A),
    .d_phase       (state == WAIT_D),
    .kill          (kill),
    .discard       (discard),
    .if_a_valid    (if_a_valid),
    .if_a_ready    (if_a_ready),
    .if_a_opcode   (if_a_opcode),
    .if_a_size     (if_a_size),
    .if_a_address  (if_a_address),
    .if_a_mask     (if_a_mask),
    .if_a_data     (if_a_data),
    .if_d_valid    (if_d_valid),
    .if_d_ready    (if_d_ready),
    .if_d_opcode   (if_d_opcode),
    .if_d_data     (if_d_data),
    .if_d_error    (if_d_error),
    .ma_a_valid    (ma_a_valid),
    .ma_a_ready    (ma_a_ready),
    .ma_a_opcode   (ma_a_opcode),
    .ma_a_size     (ma_a_size),
    .ma_a_address  (ma_a_address),
    .ma_a_mask     (ma_a_mask),
    .ma_a_data     (ma_a_data),
    .ma_d_valid    (ma_d_valid),
    .ma_d_ready    (ma_d_ready),
    .ma_d_opcode   (ma_d_opcode),
    .ma_d_data     (ma_d_data),
    .ma_d_error    (ma_d_error),
    .mem_a_valid   (mem_a_valid),
    .mem_a_ready   (mem_a_ready),
    .mem_a_opcode  (mem_a_opcode),
    .mem_a_size    (mem_a_size),
    .mem_a_address (mem_a_address),
    .mem_a_mask    (mem_a_mask),
    .mem_a_data    (mem_a_data),
    .mem_d_valid   (mem_d_valid),
    .mem_d_ready   (mem_d_ready),
    .mem_d_opcode  (mem_d_opcode),
    .mem_d_data    (mem_d_data),
    .mem_d_error   (mem_d_error)
  );
endmodule

// File: tb/tb_tl_bus_arbiter.sv
// tb_tl_bus_arbiter: directed and random stimulus checked against a transaction-level model
module tb_tl_bus_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst, clear, if_request, ma_request;
  logic        if_a_valid, if_a_ready, if_d_valid, if_d_ready, if_d_error;
  logic [2:0]  if_a_opcode, if_d_opcode;
  logic [1:0]  if_a_size;
  logic [31:0] if_a_address, if_a_data, if_d_data;
  logic [3:0]  if_a_mask;
  logic        ma_a_valid, ma_a_ready, ma_d_valid, ma_d_ready, ma_d_error;
  logic [2:0]  ma_a_opcode, ma_d_opcode;
  logic [1:0]  ma_a_size;
  logic [31:0] ma_a_address, ma_a_data, ma_d_data;
  logic [3:0]  ma_a_mask;
  logic        mem_a_valid, mem_a_ready, mem_d_valid, mem_d_ready, mem_d_error;
  logic [2:0]  mem_a_opcode, mem_d_opcode;
  logic [1:0]  mem_a_size;
  logic [31:0] mem_a_address, mem_a_data, mem_d_data;
  logic [3:0]  mem_a_mask;
  logic        grant_if, grant_ma, busy;
  int          checks = 0, passes = 0;
  // model: holder 0=none 1=IF 2=MA; issued = A sent; drop = response to discard
  int          m_hold = 0, n_hold, m_streak = 0, n_streak;
  bit          m_iss = 0, n_iss, m_drop = 0, n_drop, pend = 0, n_pend;

  always #5 clk = ~clk;

  tl_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .if_request(if_request),
    .if_a_valid(if_a_valid), .if_a_ready(if_a_ready), .if_a_opcode(if_a_opcode),
    .if_a_size(if_a_size), .if_a_address(if_a_address), .if_a_mask(if_a_mask),
    .if_a_data(if_a_data), .if_d_valid(if_d_valid), .if_d_ready(if_d_ready),
    .if_d_opcode(if_d_opcode), .if_d_data(if_d_data), .if_d_error(if_d_error),
    .ma_request(ma_request),
    .ma_a_valid(ma_a_valid), .ma_a_ready(ma_a_ready), .ma_a_opcode(ma_a_opcode),
    .ma_a_size(ma_a_size), .ma_a_address(ma_a_address), .ma_a_mask(ma_a_mask),
    .ma_a_data(ma_a_data), .ma_d_valid(ma_d_valid), .ma_d_ready(ma_d_ready),
    .ma_d_opcode(ma_d_opcode), .ma_d_data(ma_d_data), .ma_d_error(ma_d_error),
    .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_opcode(mem_a_opcode),
    .mem_a_size(mem_a_size), .mem_a_address(mem_a_address), .mem_a_mask(mem_a_mask),
    .mem_a_data(mem_a_data), .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready),
    .mem_d_opcode(mem_d_opcode), .mem_d_data(mem_d_data), .mem_d_error(mem_d_error),
    .grant_if(grant_if), .grant_ma(grant_ma), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic quiet();
    clear = 0; if_request = 0; ma_request = 0;
    if_a_valid = 0; if_a_opcode = 0; if_a_size = 2; if_a_address = 0; if_a_mask = 4'hf; if_a_data = 0; if_d_ready = 0;
    ma_a_valid = 0; ma_a_opcode = 0; ma_a_size = 2; ma_a_address = 0; ma_a_mask = 4'hf; ma_a_data = 0; ma_d_ready = 0;
    mem_a_ready = 0; mem_d_valid = 0; mem_d_opcode = 0; mem_d_data = 0; mem_d_error = 0;
  endtask

  task automatic model_check();
    bit ir, kill, a_open, d_open, mav, mdr, ifd, mad, a_fire, d_fire;
    int w;
    a_open = m_hold != 0 && !m_iss;
    d_open = m_hold != 0 && m_iss;
    kill   = m_hold == 1 && clear;
    mav    = a_open && !kill && (m_hold == 1 ? if_a_valid : ma_a_valid);
    mdr    = d_open && (m_drop || (m_hold == 1 ? if_d_ready : ma_d_ready));
    ifd    = d_open && m_hold == 1 && !m_drop && mem_d_valid;
    mad    = d_open && m_hold == 2 && mem_d_valid;
    chk("grant_if", grant_if, m_hold == 1);
    chk("grant_ma", grant_ma, m_hold == 2);
    chk("busy", busy, m_hold != 0);
    chk("mem_a_valid", mem_a_valid, mav);
    chk("if_a_ready", if_a_ready, a_open && m_hold == 1 && !kill && mem_a_ready);
    chk("ma_a_ready", ma_a_ready, a_open && m_hold == 2 && mem_a_ready);
    chk("mem_d_ready", mem_d_ready, mdr);
    chk("if_d_valid", if_d_valid, ifd);
    chk("ma_d_valid", ma_d_valid, mad);
    if (mav) chk("mem_a_address", mem_a_address, m_hold == 1 ? if_a_address : ma_a_address);
    if (mav) chk("mem_a_data", mem_a_data, m_hold == 1 ? if_a_data : ma_a_data);
    if (ifd) chk("if_d_data", if_d_data, mem_d_data);
    if (mad) chk("ma_d_data", ma_d_data, mem_d_data);
    a_fire = mav && mem_a_ready;
    d_fire = d_open && mem_d_valid && mdr;
    n_hold = m_hold; n_iss = m_iss; n_drop = m_drop; n_streak = m_streak; n_pend = pend;
    if (m_hold == 0) begin
      ir = if_request && !clear;
      w = (ma_request && m_streak < LIMIT) ? 2 : ir ? 1 : ma_request ? 2 : 0;
      if (w == 1) n_streak = 0;
      else if (w == 2) n_streak = ir ? (m_streak < LIMIT ? m_streak + 1 : LIMIT) : 0;
      n_hold = w;
      n_iss = 0;
    end else if (!m_iss) begin
      if (kill) n_hold = 0;
      else if (a_fire) begin n_iss = 1; n_pend = 1; end
    end else if (d_fire) begin
      n_hold = 0; n_drop = 0; n_pend = 0;
    end else if (kill) n_drop = 1;
    if (rst) begin n_hold = 0; n_iss = 0; n_drop = 0; n_streak = 0; n_pend = 0; end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    m_hold = n_hold; m_iss = n_iss; m_drop = n_drop; m_streak = n_streak; pend = n_pend;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    logic [9:0] seq;
    int n;
    bit prev_busy;
    quiet();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grants", {grant_if, grant_ma}, 0);
    chk("rst_mem_a_valid", mem_a_valid, 0);
    chk("rst_mem_d_ready", mem_d_ready, 0);
    // IF only: grant at 1, A fires at 1, D at 4, idle at 5
    if_request = 1; if_a_valid = 1; if_a_address = 32'h0000_1000; if_d_ready = 1; mem_a_ready = 1;
    cyc();
    if_request = 0;
    #1;
    chk("ifonly_grant_c1", grant_if, 1);
    chk("ifonly_afire_c1", if_a_ready & mem_a_valid, 1);
    chk("ifonly_addr_c1", mem_a_address, 32'h0000_1000);
    cyc();
    if_a_valid = 0; mem_a_ready = 0;
    cyc();
    cyc();
    mem_d_valid = 1; mem_d_data = 32'h0000_cafe;
    #1;
    chk("ifonly_dvalid_c4", if_d_valid, 1);
    chk("ifonly_ddata_c4", if_d_data, 32'h0000_cafe);
    cyc();
    mem_d_valid = 0;
    #1;
    chk("ifonly_idle_c5", busy, 0);
    cyc();
    // continuous contention: grant order MA x4 then IF, twice
    do_reset();
    if_request = 1; ma_request = 1; if_a_valid = 1; ma_a_valid = 1;
    if_d_ready = 1; ma_d_ready = 1; mem_a_ready = 1; mem_d_valid = 1;
    seq = 0; n = 0; prev_busy = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy && !prev_busy) begin seq = {seq[8:0], grant_if}; n++; end
      prev_busy = busy;
      cyc();
    end
    chk("starve_count", n, 10);
    chk("starve_order", seq, 10'b0000100001);
    // clear during IF WAIT_D: response drained, never shown to IF
    do_reset();
    if_request = 1; if_a_valid = 1; mem_a_ready = 1;
    cyc();
    if_request = 0;
    cyc();
    if_a_valid = 0; mem_a_ready = 0; clear = 1;
    cyc();
    clear = 0; mem_d_valid = 1; ma_request = 1;
    #1;
    chk("discard_dready", mem_d_ready, 1);
    chk("discard_dvalid", if_d_valid, 0);
    cyc();
    mem_d_valid = 0;
    cyc();
    #1;
    chk("discard_next_ma", {grant_if, grant_ma}, 2'b01);
    cyc();
    // clear in GRANT_A before IF A fire
    do_reset();
    if_request = 1; if_a_valid = 1;
    cyc();
    if_request = 0; clear = 1; mem_a_ready = 1;
    #1;
    chk("kill_mem_a_valid", mem_a_valid, 0);
    chk("kill_if_a_ready", if_a_ready, 0);
    cyc();
    clear = 0;
    #1;
    chk("kill_idle", {busy, grant_if}, 0);
    cyc();
    // MA owns while IF drives A; then reset in WAIT_D
    do_reset();
    ma_request = 1; if_request = 1; ma_a_valid = 1; if_a_valid = 1;
    ma_a_address = 32'ha000_0040; if_a_address = 32'h1111_0000;
    cyc();
    ma_request = 0; if_request = 0;
    #1;
    chk("iso_grant_ma", grant_ma, 1);
    chk("iso_if_a_ready_stall", if_a_ready, 0);
    chk("iso_addr", mem_a_address, 32'ha000_0040);
    cyc();
    mem_a_ready = 1;
    #1;
    chk("iso_if_a_ready_fire", if_a_ready, 0);
    chk("iso_ma_a_ready", ma_a_ready, 1);
    cyc();
    mem_a_ready = 0; rst = 1;
    #1;
    chk("wait_d_busy", busy, 1);
    cyc();
    rst = 0; mem_d_valid = 1; ma_d_ready = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_grants", {grant_if, grant_ma}, 0);
    chk("rst_mid_a_valid", mem_a_valid, 0);
    chk("rst_mid_ma_d_valid", ma_d_valid, 0);
    cyc();
    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = $urandom_range(0, 199) == 0;
      clear        = $urandom_range(0, 11) == 0;
      if_request   = $urandom_range(0, 9) < 6;
      ma_request   = $urandom_range(0, 1) == 1;
      if_a_valid   = $urandom_range(0, 3) != 0;
      ma_a_valid   = $urandom_range(0, 3) != 0;
      if_a_opcode  = 3'($urandom);
      ma_a_opcode  = 3'($urandom);
      if_a_address = $urandom;
      ma_a_address = $urandom;
      if_a_data    = $urandom;
      ma_a_data    = $urandom;
      if_d_ready   = $urandom_range(0, 3) != 0;
      ma_d_ready   = $urandom_range(0, 3) != 0;
      mem_a_ready  = $urandom_range(0, 2) != 0;
      mem_d_valid  = pend && ($urandom_range(0, 1) == 1);
      mem_d_data   = $urandom;
      mem_d_opcode = 3'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
